gate_sequencer: RTL and testbench
=================================

GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock.
- rst_n, in, 1: asynchronous active-low reset.
- run, in, 1: level; sequencer runs while high.
- sync, in, 1: one-cycle restart pulse.
- tempo_rate, in, 8: step period = max(tempo_rate,1) x 256 clocks.
- pattern, in, 8: bit n set means step n fires a gate.
- length, in, 3: sequence length = length+1 steps.
- gate_len, in, 8: gate-high time = gate_len x rate_eff clocks.
- swing, in, 8: swing amount; used only with the Configuration macro.
- gate, out, 1: registered; drives the envelope generator's gate.
- step_idx, out, 3: current step.
- step_tick, out, 1: high for one cycle at each step start.
- running, out, 1: sequencer active.
REQ-002 There SHALL be exactly one clock (clk) and an asynchronous active-low reset (rst_n); the block has no parameters.

Function
REQ-003 The block SHALL have two states: STOP and RUN; `running` = (state==RUN).
REQ-004 STOP->RUN: run is high and was low in the previous cycle (registered run_prev). The following cycle SHALL show running=1, step_idx=0, elapsed=0 and step_tick=1.
REQ-005 RUN->STOP: run is low. The next cycle SHALL show running=0 and gate=0; step_idx holds its value; step_tick=0.
REQ-006 At each step start (elapsed==0) the block SHALL latch rate_eff = (tempo_rate==0 ? 1 : tempo_rate), pattern[step_idx] and gate_len; mid-step input changes SHALL NOT affect the current step.
REQ-007 A 16-bit elapsed counter SHALL increment each RUN cycle. When elapsed == step_period-1, the next cycle SHALL have elapsed=0, step_tick=1 and step_idx advanced.
REQ-008 Step advance SHALL be: step_idx = (step_idx >= length) ? 0 : step_idx+1, so shrinking length mid-run wraps at the next advance.
REQ-009 gate SHALL be 1 exactly in cycles where all of the following hold:
- state is RUN;
- the latched pattern bit is 1;
- 2 <= elapsed < 2 + gate_len x rate_eff.
REQ-010 A consequence of REQ-009: gate is low for at least the first 2 cycles of every step, so back-to-back active steps always present a rising edge to the envelope. gate_len=0 gives no gate.
REQ-011 The arithmetic SHALL be:
- gate_len x rate_eff is a 16-bit unsigned product (max 65025);
- step_period = {rate_eff, 8'h00};
- no counter wraps within a step.
REQ-012 sync=1 while in RUN SHALL behave as a restart. The next cycle shows elapsed=0, step_idx=0, step_tick=1 and gate=0. sync SHALL be ignored in STOP.
REQ-013 Simultaneous run falling edge and sync: STOP SHALL win.
REQ-014 A run rising edge coinciding with sync SHALL be treated as a single start with one step_tick.

Reset
REQ-015 While rst_n=0 the block SHALL force:
- state=STOP, elapsed=0, step_idx=0;
- gate=0, step_tick=0, running=0;
- run_prev=0;
- all latched step parameters = 0.
REQ-016 Reset assertion mid-step SHALL drop gate asynchronously.
REQ-017 After reset release with run already high, the block SHALL start on the first clock, because run_prev=0 makes this a rising edge.

Configuration
REQ-018 With macro GATE_SEQ_SWING_EN defined, step lengths SHALL be modified by swing_ext = swing[7:1] x rate_eff, with swing latched at step start:
- even steps last step_period + swing_ext;
- odd steps last step_period - swing_ext;
- the pair sum is unchanged;
- gate is truncated by the step end.
REQ-019 Without GATE_SEQ_SWING_EN, the swing input SHALL be ignored (left unconnected internally) and every step SHALL last step_period.

Verification
REQ-020 Basic run: tempo_rate=1, pattern=8'hFF, length=3, gate_len=128, run 0->1.
- step_tick every 256 cycles;
- gate high at elapsed 2..129;
- step_idx sequence 0,1,2,3,0.
REQ-021 Pattern and gap: pattern=8'b0000_0101, gate_len=255, rate 1.
- gate only on steps 0 and 2 (elapsed 2..256 clipped to 255);
- a 2-cycle low precedes each high;
- step 1 gate stays 0.
REQ-022 Tempo 0 and mid-step change: tempo_rate=0.
- period 256 (rate_eff=1);
- tempo_rate changed to 2 mid-step takes effect at the next step (period 512).
REQ-023 Sync and stop:
- sync at step 2, elapsed 50 -> next cycle step_idx=0, step_tick=1, gate=0;
- run low at the same time as sync -> running=0, step_idx holds, no step_tick.
REQ-024 Length shrink: length 7->1 while step_idx=5 -> next advance goes to 0, then the sequence is 0,1,0.
REQ-025 Swing (macro on): swing=8'h40, rate 1 -> even steps 256+32=288 cycles, odd steps 224 cycles. Macro off: all steps 256 cycles.
REQ-026 Reset: rst_n pulsed mid-gate -> gate=0 immediately. After release with run high, the first step_tick follows on the first clock with step_idx=0.

Source files
------------

// File: rtl/gate_sequencer.sv
// gate_sequencer
//   Step sequencer that produces a registered gate for an envelope generator.
//   Each step lasts max(tempo_rate,1) x 256 clocks; a step whose pattern bit
//   is set raises gate from elapsed 2 up to 2 + gate_len x rate_eff (clipped
//   by the step end). Step parameters are latched when a step starts, so
//   mid-step input changes only take effect at the next step.
//
//   Optional feature: define GATE_SEQ_SWING_EN to enable swing. Even steps are
//   then lengthened and odd steps shortened by swing[7:1] x rate_eff clocks.
//   Without the macro the swing input is ignored.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   run        in   level, sequencer runs while high (starts on rising edge)
//   sync       in   one-cycle restart pulse (ignored while stopped)
//   tempo_rate in 8 step period = max(tempo_rate,1) x 256 clocks
//   pattern    in 8 bit n set -> step n fires a gate
//   length     in 3 sequence length = length+1 steps
//   gate_len   in 8 gate-high time = gate_len x rate_eff clocks
//   swing      in 8 swing amount (only used with GATE_SEQ_SWING_EN)
//   gate       out  registered gate
//   step_idx   out 3 current step
//   step_tick  out  one-cycle pulse at every step start
//   running    out  sequencer active
module gate_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       sync,
    input  logic [7:0] tempo_rate,
    input  logic [7:0] pattern,
    input  logic [2:0] length,
    input  logic [7:0] gate_len,
    input  logic [7:0] swing,
    output logic       gate,
    output logic [2:0] step_idx,
    output logic       step_tick,
    output logic       running
);

`ifdef GATE_SEQ_SWING_EN
    // A swung even step can reach 65280 + 32385 clocks, beyond 16 bits.
    localparam int EW = 17;
`else
    localparam int EW = 16;
`endif

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   elapsed_q, elapsed_d;
    logic [2:0]      step_idx_q, step_idx_d;
    logic            step_tick_q, step_tick_d;
    logic            gate_q, gate_d;
    logic            run_prev_q, run_prev_d;
    logic [7:0]      rate_q, rate_d;
    logic [7:0]      glen_q, glen_d;
    logic            pat_q, pat_d;
    logic            start_step;
    logic [15:0]     step_period;
    logic [EW-1:0]   step_len;
    logic [EW-1:0]   step_last;
    logic [15:0]     gate_prod;
    logic [16:0]     gate_end;
    logic [16:0]     elapsed_x;

    assign step_period = {rate_q, 8'h00};

`ifdef GATE_SEQ_SWING_EN
    logic [6:0]  swing_q, swing_d;
    logic [14:0] swing_ext;
    logic        unused_swing_lsb;

    assign unused_swing_lsb = swing[0];
    assign swing_ext        = {8'd0, swing_q} * {7'd0, rate_q};
    // Odd steps give back exactly what the preceding even step borrowed.
    assign step_len = step_idx_q[0] ? ({1'b0, step_period} - {2'b00, swing_ext})
                                    : ({1'b0, step_period} + {2'b00, swing_ext});
`else
    logic unused_swing;

    assign unused_swing = ^swing;
    assign step_len     = step_period;
`endif

    assign step_last = step_len - {{(EW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        elapsed_d   = elapsed_q;
        step_idx_d  = step_idx_q;
        step_tick_d = 1'b0;
        run_prev_d  = run;
        start_step  = 1'b0;

        case (state_q)
            ST_STOP: begin
                // A sync coinciding with the rising edge is just this start.
                if (run && !run_prev_q) begin
                    state_d     = ST_RUN;
                    elapsed_d   = '0;
                    step_idx_d  = 3'd0;
                    step_tick_d = 1'b1;
                    start_step  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    // Stop wins over a simultaneous sync; step_idx holds.
                    state_d = ST_STOP;
                end else if (sync) begin
                    elapsed_d   = '0;
                    step_idx_d  = 3'd0;
                    step_tick_d = 1'b1;
                    start_step  = 1'b1;
                end else if (elapsed_q == step_last) begin
                    elapsed_d   = '0;
                    // Compare with >= so a length shrunk below step_idx wraps.
                    step_idx_d  = (step_idx_q >= length) ? 3'd0 : step_idx_q + 3'd1;
                    step_tick_d = 1'b1;
                    start_step  = 1'b1;
                end else begin
                    elapsed_d = elapsed_q + {{(EW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = ST_STOP;
        endcase

        rate_d = rate_q;
        glen_d = glen_q;
        pat_d  = pat_q;
`ifdef GATE_SEQ_SWING_EN
        swing_d = swing_q;
`endif
        if (start_step) begin
            rate_d = (tempo_rate == 8'd0) ? 8'd1 : tempo_rate;
            glen_d = gate_len;
            pat_d  = pattern[step_idx_d];
`ifdef GATE_SEQ_SWING_EN
            swing_d = swing[7:1];
`endif
        end

        // Gate is computed from next-cycle values so the output is registered.
        gate_prod = {8'd0, glen_d} * {8'd0, rate_d};
        gate_end  = {1'b0, gate_prod} + 17'd2;
        elapsed_x = 17'(elapsed_d);
        gate_d    = (state_d == ST_RUN) && pat_d &&
                    (elapsed_x >= 17'd2) && (elapsed_x < gate_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOP;
            elapsed_q   <= '0;
            step_idx_q  <= 3'd0;
            step_tick_q <= 1'b0;
            gate_q      <= 1'b0;
            run_prev_q  <= 1'b0;
            rate_q      <= 8'd0;
            glen_q      <= 8'd0;
            pat_q       <= 1'b0;
`ifdef GATE_SEQ_SWING_EN
            swing_q     <= 7'd0;
`endif
        end else begin
            state_q     <= state_d;
            elapsed_q   <= elapsed_d;
            step_idx_q  <= step_idx_d;
            step_tick_q <= step_tick_d;
            gate_q      <= gate_d;
            run_prev_q  <= run_prev_d;
            rate_q      <= rate_d;
            glen_q      <= glen_d;
            pat_q       <= pat_d;
`ifdef GATE_SEQ_SWING_EN
            swing_q     <= swing_d;
`endif
        end
    end

    assign gate      = gate_q;
    assign step_idx  = step_idx_q;
    assign step_tick = step_tick_q;
    assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_gate_sequencer.sv
`timescale 1ns/1ps
module tb_gate_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       sync;
    logic [7:0] tempo_rate;
    logic [7:0] pattern;
    logic [2:0] length;
    logic [7:0] gate_len;
    logic [7:0] swing;
    logic       gate;
    logic [2:0] step_idx;
    logic       step_tick;
    logic       running;

    gate_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .sync       (sync),
        .tempo_rate (tempo_rate),
        .pattern    (pattern),
        .length     (length),
        .gate_len   (gate_len),
        .swing      (swing),
        .gate       (gate),
        .step_idx   (step_idx),
        .step_tick  (step_tick),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int cyc;
    } tick_t;
    tick_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input int idx, input int c);
        tick_t t;
        t.idx = idx;
        t.cyc = c;
        exp_q.push_back(t);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard: every observed step_tick must match the next expected entry.
    always @(negedge clk) begin
        tick_t e;
        if (rst_n === 1'b1 && step_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 32'(step_tick), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_idx", 32'(step_idx), 32'(e.idx));
                chk("tick_cycle", 32'(cyc), 32'(e.cyc));
                $display("tick idx=%0d cycle=%0d (expected idx=%0d cycle=%0d)",
                         step_idx, cyc, e.idx, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int c0, s, r, sw, p0, p1, t0, e_last;

    initial begin
        rst_n = 1'b0; run = 1'b0; sync = 1'b0; tempo_rate = 8'd0;
        pattern = 8'd0; length = 3'd0; gate_len = 8'd0; swing = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_tick", 32'(step_tick), 32'd0);
        chk("rst_idx", 32'(step_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run
        tempo_rate = 8'd1; pattern = 8'hFF; length = 3'd3; gate_len = 8'd128;
        c0 = cyc; run = 1'b1;
        for (int k = 0; k < 5; k++) push(k % 4, c0 + 1 + 256 * k);
        at_cyc(c0 + 1);
        chk("basic_running", 32'(running), 32'd1);
        chk("basic_idx0", 32'(step_idx), 32'd0);
        chk("basic_gate_e0", 32'(gate), 32'd0);
        at_cyc(c0 + 2);   chk("basic_gate_e1", 32'(gate), 32'd0);
        at_cyc(c0 + 3);   chk("basic_gate_e2", 32'(gate), 32'd1);
        at_cyc(c0 + 130); chk("basic_gate_e129", 32'(gate), 32'd1);
        at_cyc(c0 + 131); chk("basic_gate_e130", 32'(gate), 32'd0);
        at_cyc(c0 + 1035);
        chk("basic_gate_before_stop", 32'(gate), 32'd1);
        run = 1'b0;
        at_cyc(c0 + 1036);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_gate", 32'(gate), 32'd0);
        chk("stop_idx", 32'(step_idx), 32'd0);
        chk("basic_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // Pattern with gaps, gate clipped by the step end
        pattern = 8'b0000_0101; gate_len = 8'd255;
        c0 = cyc; run = 1'b1;
        for (int k = 0; k < 4; k++) push(k, c0 + 1 + 256 * k);
        at_cyc(c0 + 2);   chk("pat_s0_e1", 32'(gate), 32'd0);
        at_cyc(c0 + 3);   chk("pat_s0_e2", 32'(gate), 32'd1);
        at_cyc(c0 + 256); chk("pat_s0_e255", 32'(gate), 32'd1);
        at_cyc(c0 + 357); chk("pat_s1_e100", 32'(gate), 32'd0);
        at_cyc(c0 + 514); chk("pat_s2_e1", 32'(gate), 32'd0);
        at_cyc(c0 + 515); chk("pat_s2_e2", 32'(gate), 32'd1);
        at_cyc(c0 + 768); chk("pat_s2_e255", 32'(gate), 32'd1);
        at_cyc(c0 + 769); chk("pat_s3_e0", 32'(gate), 32'd0);
        at_cyc(c0 + 800); chk("pat_s3_e31", 32'(gate), 32'd0);
        run = 1'b0;
        at_cyc(c0 + 803);

        // Tempo 0, mid-step tempo change, then sync and stop+sync
        tempo_rate = 8'd0; pattern = 8'hFF; gate_len = 8'd1; length = 3'd7;
        c0 = cyc; run = 1'b1;
        push(0, c0 + 1); push(1, c0 + 257); push(2, c0 + 769);
        at_cyc(c0 + 3);   chk("t0_s0_e2", 32'(gate), 32'd1);
        at_cyc(c0 + 4);   chk("t0_s0_e3", 32'(gate), 32'd0);
        at_cyc(c0 + 100); tempo_rate = 8'd2;
        at_cyc(c0 + 259); chk("t2_s1_e2", 32'(gate), 32'd1);
        at_cyc(c0 + 260); chk("t2_s1_e3", 32'(gate), 32'd1);
        at_cyc(c0 + 261); chk("t2_s1_e4", 32'(gate), 32'd0);
        at_cyc(c0 + 819);
        sync = 1'b1; tempo_rate = 8'd1;
        s = c0 + 820;
        push(0, s);
        at_cyc(s);
        sync = 1'b0;
        chk("sync_idx", 32'(step_idx), 32'd0);
        chk("sync_tick", 32'(step_tick), 32'd1);
        chk("sync_gate", 32'(gate), 32'd0);
        push(1, s + 256);
        at_cyc(s + 300);
        run = 1'b0; sync = 1'b1;
        at_cyc(s + 301);
        sync = 1'b0;
        chk("stopsync_running", 32'(running), 32'd0);
        chk("stopsync_idx", 32'(step_idx), 32'd1);
        chk("stopsync_tick", 32'(step_tick), 32'd0);
        chk("stopsync_gate", 32'(gate), 32'd0);
        at_cyc(s + 303);

        // Length shrink while step_idx = 5
        tempo_rate = 8'd1; length = 3'd7; gate_len = 8'd4; pattern = 8'hFF;
        c0 = cyc; run = 1'b1;
        for (int k = 0; k < 6; k++) push(k, c0 + 1 + 256 * k);
        push(0, c0 + 1 + 1536); push(1, c0 + 1 + 1792); push(0, c0 + 1 + 2048);
        at_cyc(c0 + 1 + 1280 + 10);
        chk("shrink_idx5", 32'(step_idx), 32'd5);
        length = 3'd1;
        at_cyc(c0 + 1 + 2048 + 5);
        run = 1'b0;
        at_cyc(c0 + 1 + 2048 + 7);
        chk("shrink_queue", 32'(exp_q.size()), 32'd0);

        // Swing (no effect unless the feature is built in)
`ifdef GATE_SEQ_SWING_EN
        sw = 32;
`else
        sw = 0;
`endif
        p0 = 256 + sw; p1 = 256 - sw;
        swing = 8'h40; gate_len = 8'd255; length = 3'd3;
        c0 = cyc; run = 1'b1; t0 = c0 + 1;
        push(0, t0); push(1, t0 + p0); push(2, t0 + p0 + p1);
        push(3, t0 + 2 * p0 + p1); push(0, t0 + 2 * p0 + 2 * p1);
        e_last = p0 - 1;
        at_cyc(t0 + p0 - 1);
        chk("swing_even_last", 32'(gate), ((e_last >= 2) && (e_last < 257)) ? 32'd1 : 32'd0);
        at_cyc(t0 + p0 + p1 - 1); chk("swing_odd_last", 32'(gate), 32'd1);
        at_cyc(t0 + p0 + p1);     chk("swing_even2_e0", 32'(gate), 32'd0);
        at_cyc(t0 + 2 * p0 + 2 * p1 + 3);
        run = 1'b0; swing = 8'd0;
        at_cyc(t0 + 2 * p0 + 2 * p1 + 5);
        chk("swing_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-gate, restart with run already high
        tempo_rate = 8'd1; pattern = 8'hFF; gate_len = 8'd128; length = 3'd3;
        c0 = cyc; run = 1'b1;
        push(0, c0 + 1);
        at_cyc(c0 + 51);
        chk("rstmid_gate_before", 32'(gate), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_gate", 32'(gate), 32'd0);
        chk("rstmid_running", 32'(running), 32'd0);
        chk("rstmid_tick", 32'(step_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push(0, r + 1);
        at_cyc(r + 1);
        chk("rstrel_running", 32'(running), 32'd1);
        chk("rstrel_idx", 32'(step_idx), 32'd0);
        chk("rstrel_gate_e0", 32'(gate), 32'd0);
        at_cyc(r + 4);
        chk("rstrel_gate_e3", 32'(gate), 32'd1);
        run = 1'b0;
        at_cyc(r + 6);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
